image_write: RTL and testbench

- Writes a processed feature-map stream back into image memory. It is the write-side counterpart of the image read engine.
- Accepts a valid/ready/last stream of GROUP_NB packed pixels per beat.
- Produces one memory write per accepted beat at a strided 2-D address sequence, set up over the shared cfg bus.
- Sits between the compute pipeline output and the image memory write port.

---
 rtl/image_write.sv | 148 ++++++++++++++
 tb/tb_image_write.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_write.sv
// image_write: writes a valid/ready pixel stream to image memory along a strided 2-D address walk.
// Optional image_last cross-check with sticky err output: define IMAGE_WRITE_LAST_CHECK_EN.
module image_write #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_BASE   = 8,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  output logic                          busy,
  output logic                          done,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
  input  logic                          image_last,
  input  logic                          image_val,
  output logic                          image_rdy,
  output logic                          wr_val,
  output logic [MEM_AWIDTH-1:0]         wr_addr,
  output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data
`ifdef IMAGE_WRITE_LAST_CHECK_EN
  ,
  output logic                          err
`endif
);

  localparam logic [CFG_AWIDTH-1:0] REG_START  = CFG_AWIDTH'(CFG_BASE);
  localparam logic [CFG_AWIDTH-1:0] REG_LEN    = CFG_AWIDTH'(CFG_BASE + 1);
  localparam logic [CFG_AWIDTH-1:0] REG_CNT    = CFG_AWIDTH'(CFG_BASE + 2);
  localparam logic [CFG_AWIDTH-1:0] REG_STRIDE = CFG_AWIDTH'(CFG_BASE + 3);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;
  state_t state, state_nx;

  logic [MEM_AWIDTH-1:0] start_q, len_q, cnt_q, stride_q;
  logic [MEM_AWIDTH-1:0] len_w, cnt_w, stride_w, col, row, row_base, addr;
  logic accept, last_col, last_row, frame_end, go, empty;
  logic unused_bits;

  assign accept   = image_val & image_rdy;
  assign last_col = (col == len_w - MEM_AWIDTH'(1));
  assign last_row = (row == cnt_w - MEM_AWIDTH'(1));
  assign empty    = (len_q == '0) || (cnt_q == '0);
  assign go       = (state == IDLE) && next && !empty;

`ifdef IMAGE_WRITE_LAST_CHECK_EN
  assign frame_end   = accept & ((last_col & last_row) | image_last);
  assign unused_bits = ^cfg_data[CFG_DWIDTH-1:MEM_AWIDTH];
`else
  assign frame_end   = accept & last_col & last_row;
  assign unused_bits = ^{cfg_data[CFG_DWIDTH-1:MEM_AWIDTH], image_last};
`endif

  // Shadow registers; the frame runs from the working copies latched at start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      stride_q <= '0;
    end else if (cfg_valid) begin
      case (cfg_addr)
        REG_START:  start_q  <= cfg_data[MEM_AWIDTH-1:0];
        REG_LEN:    len_q    <= cfg_data[MEM_AWIDTH-1:0];
        REG_CNT:    cnt_q    <= cfg_data[MEM_AWIDTH-1:0];
        REG_STRIDE: stride_q <= cfg_data[MEM_AWIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = WRITE;
      WRITE:   if (frame_end) state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    image_rdy = (state == WRITE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr     <= '0;
      len_w    <= '0;
      cnt_w    <= '0;
      stride_w <= '0;
      wr_val   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      wr_val <= accept;
      done   <= (state == FLUSH) || ((state == IDLE) && next && empty);
      if (accept) begin
        wr_addr <= addr;
        wr_data <= image_bus;
      end
      if (go) begin
        col      <= '0;
        row      <= '0;
        row_base <= start_q;
        addr     <= start_q;
        len_w    <= len_q;
        cnt_w    <= cnt_q;
        stride_w <= stride_q;
      end else if (accept) begin
        if (last_col) begin
          col      <= '0;
          row      <= row + MEM_AWIDTH'(1);
          row_base <= row_base + stride_w;
          addr     <= row_base + stride_w;
        end else begin
          col  <= col + MEM_AWIDTH'(1);
          addr <= addr + MEM_AWIDTH'(1);
        end
      end
    end
  end

`ifdef IMAGE_WRITE_LAST_CHECK_EN
  // Flags any disagreement between image_last and the configured frame length.
  always_ff @(posedge clk) begin
    if (!rst)                           err <= 1'b0;
    else if ((state == IDLE) && next)   err <= 1'b0;
    else if (accept && ((last_col & last_row) != image_last)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_image_write.sv
// Directed self-checking bench for image_write.
module tb_image_write;

  localparam int CFG_BASE = 8;

  logic        clk, rst;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid, next, busy, done;
  logic [63:0] image_bus;
  logic        image_last, image_val, image_rdy;
  logic        wr_val;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
`ifdef IMAGE_WRITE_LAST_CHECK_EN
  logic        err;
`endif

  image_write #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .CFG_BASE(CFG_BASE),
    .GROUP_NB(4), .IMG_WIDTH(16), .MEM_AWIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .next(next), .busy(busy), .done(done),
    .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
    .image_rdy(image_rdy),
    .wr_val(wr_val), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMAGE_WRITE_LAST_CHECK_EN
    , .err(err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] obs_addr[$];
  logic [63:0] obs_data[$];
  int lat_bad, done_cnt, done_cyc, last_acc_cyc;
  logic busy_first, busy_at_done, rdy_after_last;

  function automatic logic [63:0] pix(input int i);
    return {4{16'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_frame(input logic [15:0] s, input logic [15:0] l,
                           input logic [15:0] c, input logic [15:0] st);
    cfg_write(5'(CFG_BASE + 0), {16'hABCD, s});
    cfg_write(5'(CFG_BASE + 1), 32'(l));
    cfg_write(5'(CFG_BASE + 2), 32'(c));
    cfg_write(5'(CFG_BASE + 3), 32'(st));
  endtask

  // Pulses next, offers up to n beats and records what appears on the write port.
  task automatic drive_frame(input int n, input bit toggle, input int last_idx,
                             input int next_at, input int budget);
    int sent = 0;
    int cyc = 0;
    bit acc_prev = 1'b0;
    obs_addr.delete();
    obs_data.delete();
    lat_bad = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -10;
    busy_first = 1'b0; busy_at_done = 1'b1; rdy_after_last = 1'b1;
    next = 1'b1;
    tick();
    next = 1'b0;
    busy_first = busy;
    while (cyc < budget) begin
      if (wr_val) begin
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
        if (!acc_prev) lat_bad++;
      end else if (acc_prev) begin
        lat_bad++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      if (cyc == last_acc_cyc + 1) rdy_after_last = image_rdy;
      image_val  = (sent < n) && (!toggle || (cyc % 2 == 0));
      image_bus  = pix(sent + 1);
      image_last = (sent == last_idx);
      next       = (cyc == next_at);
      acc_prev   = image_val && image_rdy;
      if (acc_prev) begin
        sent++;
        last_acc_cyc = cyc;
      end
      tick();
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
    end
    image_val  = 1'b0;
    image_last = 1'b0;
    next       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (image_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", image_rdy); end
    vectors++; if (wr_val !== 1'b0) begin miscompares++; $display("FAIL reset_wr_val: got %b want 0", wr_val); end
    vectors++; if (wr_addr !== 16'h0) begin miscompares++; $display("FAIL reset_wr_addr: got %h want 0000", wr_addr); end
    vectors++; if (wr_data !== 64'h0) begin miscompares++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic check_2d(input string tag, input logic [15:0] start, input bit toggle);
    logic [15:0] ea;
    drive_frame(8, toggle, 7, -1, 80);
    vectors++; if (obs_addr.size() != 8) begin miscompares++; $display("FAIL %s_count: got %0d want 8", tag, obs_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      ea = start + 16'(i % 4) + 16'(8 * (i / 4));
      vectors++; if (obs_addr[i] !== ea) begin miscompares++; $display("FAIL %s_addr[%0d]: got %h want %h", tag, i, obs_addr[i], ea); end
      vectors++; if (obs_data[i] !== pix(i + 1)) begin miscompares++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, obs_data[i], pix(i + 1)); end
    end
    vectors++; if (busy_first !== 1'b1) begin miscompares++; $display("FAIL %s_busy_start: got %b want 1", tag, busy_first); end
    vectors++; if (lat_bad != 0) begin miscompares++; $display("FAIL %s_latency: got %0d bad cycles want 0", tag, lat_bad); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt); end
    vectors++; if (done_cyc != last_acc_cyc + 2) begin miscompares++; $display("FAIL %s_done_timing: got cycle %0d want %0d", tag, done_cyc, last_acc_cyc + 2); end
    vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL %s_busy_at_done: got %b want 0", tag, busy_at_done); end
    vectors++; if (rdy_after_last !== 1'b0) begin miscompares++; $display("FAIL %s_rdy_after_last: got %b want 0", tag, rdy_after_last); end
  endtask

  task automatic test_contiguous();
    cfg_frame(16'h0100, 16'd4, 16'd2, 16'd8);
    cfg_write(5'(CFG_BASE + 4), 32'h7777);
    cfg_write(5'(CFG_BASE - 8), 32'h7777);
    check_2d("contig", 16'h0100, 1'b0);
  endtask

  task automatic test_toggle();
    check_2d("toggle", 16'h0100, 1'b1);
  endtask

  task automatic test_wrap();
    logic [15:0] ea;
    cfg_frame(16'hFFFE, 16'd4, 16'd1, 16'd8);
    drive_frame(4, 1'b0, 3, -1, 40);
    vectors++; if (obs_addr.size() != 4) begin miscompares++; $display("FAIL wrap_count: got %0d want 4", obs_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      ea = 16'hFFFE + 16'(i);
      vectors++; if (obs_addr[i] !== ea) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, obs_addr[i], ea); end
    end
  endtask

  task automatic test_zero_len_and_busy_next();
    cfg_frame(16'h0010, 16'd0, 16'd3, 16'd1);
    next = 1'b1;
    tick();
    next = 1'b0;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b want 1", done); end
    vectors++; if (wr_val !== 1'b0) begin miscompares++; $display("FAIL zero_wr_val: got %b want 0", wr_val); end
    vectors++; if (image_rdy !== 1'b0) begin miscompares++; $display("FAIL zero_rdy: got %b want 0", image_rdy); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b want 0", busy); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    cfg_frame(16'h0020, 16'd4, 16'd1, 16'd1);
    drive_frame(4, 1'b0, 3, 2, 40);
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL busy_next_done_count: got %0d want 1", done_cnt); end
    vectors++; if (obs_addr.size() != 4) begin miscompares++; $display("FAIL busy_next_count: got %0d want 4", obs_addr.size()); end
    vectors++; if (obs_addr[3] !== 16'h0023) begin miscompares++; $display("FAIL busy_next_addr3: got %h want 0023", obs_addr[3]); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_next_restart: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    cfg_frame(16'h0040, 16'd4, 16'd2, 16'd8);
    next = 1'b1;
    tick();
    next = 1'b0;
    for (int i = 0; i < 3; i++) begin
      image_val = 1'b1;
      image_bus = pix(i + 1);
      tick();
    end
    vectors++; if (wr_addr !== 16'h0042) begin miscompares++; $display("FAIL mid_wr_addr3: got %h want 0042", wr_addr); end
    rst = 1'b0;
    image_bus = pix(4);
    tick();
    rst = 1'b1;
    image_val = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    vectors++; if (wr_val !== 1'b0) begin miscompares++; $display("FAIL mid_wr_val: got %b want 0", wr_val); end
    vectors++; if (image_rdy !== 1'b0) begin miscompares++; $display("FAIL mid_rdy: got %b want 0", image_rdy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b want 0", done); end
    vectors++; if (wr_addr !== 16'h0) begin miscompares++; $display("FAIL mid_wr_addr: got %h want 0000", wr_addr); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done_late: got %b want 0", done); end
    cfg_frame(16'h0040, 16'd4, 16'd2, 16'd8);
    drive_frame(8, 1'b0, 7, -1, 80);
    vectors++; if (obs_addr.size() != 8) begin miscompares++; $display("FAIL restart_count: got %0d want 8", obs_addr.size()); end
    vectors++; if (obs_addr[0] !== 16'h0040) begin miscompares++; $display("FAIL restart_addr0: got %h want 0040", obs_addr[0]); end
    vectors++; if (obs_addr[7] !== 16'h004B) begin miscompares++; $display("FAIL restart_addr7: got %h want 004b", obs_addr[7]); end
  endtask

`ifdef IMAGE_WRITE_LAST_CHECK_EN
  task automatic test_last_check();
    cfg_frame(16'h0100, 16'd4, 16'd2, 16'd8);
    drive_frame(8, 1'b0, 4, -1, 80);
    vectors++; if (obs_addr.size() != 5) begin miscompares++; $display("FAIL early_count: got %0d want 5", obs_addr.size()); end
    vectors++; if (obs_addr[4] !== 16'h0108) begin miscompares++; $display("FAIL early_addr4: got %h want 0108", obs_addr[4]); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL early_err: got %b want 1", err); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL early_done: got %0d want 1", done_cnt); end
    drive_frame(8, 1'b0, 7, -1, 80);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b want 0", err); end
    vectors++; if (obs_addr.size() != 8) begin miscompares++; $display("FAIL clean_count: got %0d want 8", obs_addr.size()); end
    drive_frame(8, 1'b0, -1, -1, 80);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL missing_last_err: got %b want 1", err); end
    vectors++; if (obs_addr.size() != 8) begin miscompares++; $display("FAIL missing_last_count: got %0d want 8", obs_addr.size()); end
  endtask
`endif

  initial begin
    rst = 1'b0; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0; next = 1'b0;
    image_bus = '0; image_last = 1'b0; image_val = 1'b0;
    test_reset();
    test_contiguous();
    test_toggle();
    test_wrap();
    test_zero_len_and_busy_next();
    test_reset_mid();
`ifdef IMAGE_WRITE_LAST_CHECK_EN
    test_last_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
